// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    localparam int RGB_W = 12;

    // Entry i is the colour of bar i, counting from the left edge of the screen.
    localparam logic [7:0][RGB_W-1:0] BAR_COLOURS = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

endpackage

// File: rtl/vga_pattern_lut.sv
// Combinational colour selection for one pixel given the active pattern.
// No state; the caller decides visibility and registers the result.
module vga_pattern_lut
    import vga_pkg::*;
#(
    parameter int BAR_WIDTH  = 80,
    parameter int CHECK_LOG2 = 5
) (
    input  logic [1:0]       mode_i,
    input  logic [9:0]       hc_i,
    input  logic [9:0]       vc_i,
    input  logic [7:0]       frame_cnt_i,
    input  logic [RGB_W-1:0] solid_i,
    output logic [RGB_W-1:0] rgb_o
);

    logic [9:0] bar_div;
    logic [2:0] bar_idx;
    logic [3:0] grad_r;
    logic       vc_unused;

    assign bar_div   = hc_i / 10'(BAR_WIDTH);
    assign bar_idx   = (bar_div > 10'd7) ? 3'd7 : bar_div[2:0];
    assign grad_r    = hc_i[9:6] + frame_cnt_i[3:0];
    assign vc_unused = ^vc_i;

    always_comb begin
        rgb_o = '0;
        case (mode_e'(mode_i))
            MODE_BARS:     rgb_o = BAR_COLOURS[bar_idx];
            MODE_CHECKER:  rgb_o = (hc_i[CHECK_LOG2] ^ vc_i[CHECK_LOG2]) ? 12'hFFF : 12'h000;
            MODE_GRADIENT: rgb_o = {grad_r, vc_i[8:5], frame_cnt_i[7:4]};
            MODE_SOLID:    rgb_o = solid_i;
            default:       rgb_o = '0;
        endcase
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator behind a 640x480 timing driver: bars, checker, gradient, solid.
// rgb/hs/vs lag their inputs by two clk_vga cycles; mode and solid colour change only on vs falling.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int BAR_WIDTH  = 80,
    parameter int CHECK_LOG2 = 5
) (
    input  logic             clk_vga,
    input  logic             rst,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic [9:0]       hc_visible,
    input  logic [9:0]       vc_visible,
    input  logic             mode_step,
    input  logic [RGB_W-1:0] solid_rgb,
    output logic             hs,
    output logic             vs,
    output logic [RGB_W-1:0] rgb,
    output logic [1:0]       mode,
    output logic [7:0]       frame_cnt
);

    mode_e            mode_q, mode_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             pend_q, pend_d;
    logic [RGB_W-1:0] solid_q, solid_d;
    logic             vs_prev_q;
    logic             frame_edge;

    logic [9:0]       hc_s1_q, vc_s1_q;
    logic             vis_s1_q, hs_s1_q, vs_s1_q;
    logic [1:0]       mode_s1_q;
    logic [7:0]       frame_cnt_s1_q;
    logic [RGB_W-1:0] solid_s1_q;

    logic [RGB_W-1:0] lut_rgb, rgb_d;
    logic [RGB_W-1:0] rgb_q;
    logic             hs_q, vs_q;

    assign frame_edge = vs_prev_q & ~vs_in;

    // Step requests are remembered until the next frame edge, so several pulses collapse to one step.
    always_comb begin
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        pend_d      = pend_q | mode_step;
        solid_d     = solid_q;
        if (frame_edge) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            solid_d     = solid_rgb;
            pend_d      = 1'b0;
            if (pend_q | mode_step) begin
                mode_d = mode_e'(mode_q + 2'd1);
            end
        end
    end

    vga_pattern_lut #(
        .BAR_WIDTH  (BAR_WIDTH),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_lut (
        .mode_i      (mode_s1_q),
        .hc_i        (hc_s1_q),
        .vc_i        (vc_s1_q),
        .frame_cnt_i (frame_cnt_s1_q),
        .solid_i     (solid_s1_q),
        .rgb_o       (lut_rgb)
    );

    assign rgb_d = vis_s1_q ? lut_rgb : '0;

    // Stage 1 snapshots the control registers with the pixel so all fields switch on the same pixel.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            mode_q         <= MODE_BARS;
            frame_cnt_q    <= '0;
            pend_q         <= 1'b0;
            solid_q        <= '0;
            vs_prev_q      <= 1'b1;
            hc_s1_q        <= '0;
            vc_s1_q        <= '0;
            vis_s1_q       <= 1'b0;
            hs_s1_q        <= 1'b1;
            vs_s1_q        <= 1'b1;
            mode_s1_q      <= '0;
            frame_cnt_s1_q <= '0;
            solid_s1_q     <= '0;
            rgb_q          <= '0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
        end else begin
            mode_q         <= mode_d;
            frame_cnt_q    <= frame_cnt_d;
            pend_q         <= pend_d;
            solid_q        <= solid_d;
            vs_prev_q      <= vs_in;
            hc_s1_q        <= hc_visible;
            vc_s1_q        <= vc_visible;
            vis_s1_q       <= (hc_visible != 10'd0) && (vc_visible != 10'd0);
            hs_s1_q        <= hs_in;
            vs_s1_q        <= vs_in;
            mode_s1_q      <= mode_q;
            frame_cnt_s1_q <= frame_cnt_q;
            solid_s1_q     <= solid_q;
            rgb_q          <= rgb_d;
            hs_q           <= hs_s1_q;
            vs_q           <= vs_s1_q;
        end
    end

    assign rgb       = rgb_q;
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign mode      = mode_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
`timescale 1ns/1ps
module tb_vga_pattern_gen;

    logic        clk_vga = 1'b0;
    logic        rst;
    logic        hs_in, vs_in, mode_step;
    logic [9:0]  hc_visible, vc_visible;
    logic [11:0] solid_rgb;
    logic        hs, vs;
    logic [11:0] rgb;
    logic [1:0]  mode;
    logic [7:0]  frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entries are {hs, vs, rgb} expected two cycles after the push.
    logic [13:0] exp_q[$];

    // Reference state of the pattern controls.
    logic [1:0]  m_mode;
    logic [7:0]  m_fcnt;
    logic        m_pend;
    logic [11:0] m_solid;

    vga_pattern_gen #(.BAR_WIDTH(80), .CHECK_LOG2(5)) dut (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .hc_visible (hc_visible),
        .vc_visible (vc_visible),
        .mode_step  (mode_step),
        .solid_rgb  (solid_rgb),
        .hs         (hs),
        .vs         (vs),
        .rgb        (rgb),
        .mode       (mode),
        .frame_cnt  (frame_cnt)
    );

    always #20 clk_vga = ~clk_vga;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete within 1 ms");
        $fatal(1);
    end

    function automatic logic [11:0] exp_rgb(input logic [9:0] hc, input logic [9:0] vc);
        int         idx;
        logic [3:0] r;
        if (hc == 10'd0 || vc == 10'd0) return 12'h000;
        case (m_mode)
            2'd0: begin
                idx = int'(hc) / 80;
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 12'hFFF;
                    1: return 12'hFF0;
                    2: return 12'h0FF;
                    3: return 12'h0F0;
                    4: return 12'hF0F;
                    5: return 12'hF00;
                    6: return 12'h00F;
                    default: return 12'h000;
                endcase
            end
            2'd1: return (hc[5] ^ vc[5]) ? 12'hFFF : 12'h000;
            2'd2: begin
                r = hc[9:6] + m_fcnt[3:0];
                return {r, vc[8:5], m_fcnt[7:4]};
            end
            default: return m_solid;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic push_px(input logic [9:0] hc, input logic [9:0] vc, input logic h);
        hc_visible = hc;
        vc_visible = vc;
        hs_in      = h;
        vs_in      = 1'b1;
        exp_q.push_back({h, 1'b1, exp_rgb(hc, vc)});
    endtask

    task automatic model_edge();
        m_fcnt  = m_fcnt + 8'd1;
        m_solid = solid_rgb;
        if (m_pend) m_mode = m_mode + 2'd1;
        m_pend  = 1'b0;
    endtask

    task automatic idle_inputs();
        hc_visible = '0;
        vc_visible = '0;
        hs_in      = 1'b1;
        vs_in      = 1'b1;
    endtask

    task automatic do_edge();
        idle_inputs();
        tick();
        vs_in = 1'b0;
        tick();
        model_edge();
        vs_in = 1'b1;
        tick();
        tick();
    endtask

    task automatic pulse_step();
        mode_step = 1'b1;
        tick();
        mode_step = 1'b0;
        m_pend    = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        mode_step = 1'b0;
        solid_rgb = 12'h5A5;
        idle_inputs();
        repeat (3) tick();
        n_cmp += 5;
        if (rgb !== 12'h000) begin n_err++; $display("FAIL reset rgb: got %h want 000", rgb); end
        if (hs !== 1'b1)     begin n_err++; $display("FAIL reset hs: got %b want 1", hs); end
        if (vs !== 1'b1)     begin n_err++; $display("FAIL reset vs: got %b want 1", vs); end
        if (mode !== 2'd0)   begin n_err++; $display("FAIL reset mode: got %0d want 0", mode); end
        if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL reset frame_cnt: got %0d want 0", frame_cnt); end
        rst     = 1'b0;
        m_mode  = 2'd0;
        m_fcnt  = 8'd0;
        m_pend  = 1'b0;
        m_solid = 12'h000;
        tick();
    endtask

    task automatic test_latency();
        logic [13:0] e;
        push_px(10'd85, 10'd10, 1'b0);
        tick();
        n_cmp++;
        if (rgb !== 12'h000 || hs !== 1'b1) begin
            n_err++; $display("FAIL latency_early: got rgb=%h hs=%b want rgb=000 hs=1", rgb, hs);
        end
        idle_inputs();
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if ({hs, vs, rgb} !== {1'b0, 1'b1, 12'hFF0}) begin
            n_err++; $display("FAIL latency_bar1: got hs=%b vs=%b rgb=%h want hs=0 vs=1 rgb=FF0 (model %h)", hs, vs, rgb, e[11:0]);
        end
        vs_in = 1'b0;
        tick();
        model_edge();
        n_cmp++;
        if (vs !== 1'b1) begin n_err++; $display("FAIL vs_delay1: got %b want 1", vs); end
        vs_in = 1'b1;
        tick();
        n_cmp++;
        if (vs !== 1'b0) begin n_err++; $display("FAIL vs_delay2: got %b want 0", vs); end
        tick();
        n_cmp++;
        if (vs !== 1'b1) begin n_err++; $display("FAIL vs_delay3: got %b want 1", vs); end
        n_cmp++;
        if (frame_cnt !== m_fcnt) begin n_err++; $display("FAIL latency frame_cnt: got %0d want %0d", frame_cnt, m_fcnt); end
    endtask

    task automatic test_bars_blank();
        logic [9:0]  hv [15] = '{10'd0, 10'd100, 10'd0, 10'd1, 10'd79, 10'd80, 10'd159, 10'd160,
                                 10'd240, 10'd320, 10'd400, 10'd480, 10'd560, 10'd639, 10'd1000};
        logic [9:0]  vv [15] = '{10'd100, 10'd0, 10'd0, 10'd10, 10'd10, 10'd10, 10'd479, 10'd1,
                                 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1};
        logic [13:0] e;
        for (int i = 0; i <= 15; i++) begin
            if (i < 15) push_px(hv[i], vv[i], i[0]);
            tick();
            if (i >= 1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({hs, vs, rgb} !== e) begin
                    n_err++;
                    $display("FAIL bars[%0d]: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                             i - 1, hs, vs, rgb, e[13], e[12], e[11:0]);
                end
            end
        end
    endtask

    task automatic test_mode_step();
        logic [9:0]  hv [5] = '{10'd32, 10'd32, 10'd1, 10'd33, 10'd0};
        logic [9:0]  vv [5] = '{10'd1, 10'd32, 10'd1, 10'd40, 10'd100};
        logic [13:0] e;
        idle_inputs();
        repeat (3) begin
            pulse_step();
            tick();
        end
        n_cmp++;
        if (mode !== 2'd0) begin n_err++; $display("FAIL step_held: got mode %0d want 0", mode); end
        do_edge();
        n_cmp += 2;
        if (mode !== 2'd1) begin n_err++; $display("FAIL step_once: got mode %0d want 1", mode); end
        if (frame_cnt !== m_fcnt) begin n_err++; $display("FAIL step frame_cnt: got %0d want %0d", frame_cnt, m_fcnt); end
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) push_px(hv[i], vv[i], 1'b1);
            tick();
            if (i >= 1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({hs, vs, rgb} !== e) begin
                    n_err++;
                    $display("FAIL checker[%0d]: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                             i - 1, hs, vs, rgb, e[13], e[12], e[11:0]);
                end
            end
        end
    endtask

    task automatic test_gradient_wrap();
        idle_inputs();
        tick();
        vs_in     = 1'b0;
        mode_step = 1'b1;
        tick();
        mode_step = 1'b0;
        m_pend    = 1'b1;
        model_edge();
        vs_in = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (mode !== 2'd2) begin n_err++; $display("FAIL step_at_edge: got mode %0d want 2", mode); end
        while (m_fcnt != 8'h13) do_edge();
        hc_visible = 10'd64; vc_visible = 10'd32;
        repeat (2) tick();
        n_cmp++;
        if (rgb !== 12'h411) begin n_err++; $display("FAIL gradient_13: got %h want 411", rgb); end
        while (m_fcnt != 8'hFF) do_edge();
        n_cmp++;
        if (frame_cnt !== 8'hFF) begin n_err++; $display("FAIL frame_cnt_ff: got %0d want 255", frame_cnt); end
        do_edge();
        n_cmp++;
        if (frame_cnt !== 8'h00) begin n_err++; $display("FAIL frame_cnt_wrap: got %0d want 0", frame_cnt); end
        hc_visible = 10'd64; vc_visible = 10'd32;
        repeat (2) tick();
        n_cmp++;
        if (rgb !== 12'h110) begin n_err++; $display("FAIL gradient_00: got %h want 110", rgb); end
        hc_visible = 10'd639; vc_visible = 10'd479;
        repeat (2) tick();
        n_cmp++;
        if (rgb !== 12'h9E0) begin n_err++; $display("FAIL gradient_corner: got %h want 9E0", rgb); end
    endtask

    task automatic test_solid();
        logic [9:0]  hv [4] = '{10'd10, 10'd0, 10'd300, 10'd639};
        logic [9:0]  vv [4] = '{10'd10, 10'd10, 10'd200, 10'd479};
        logic [13:0] e;
        solid_rgb = 12'h123;
        pulse_step();
        do_edge();
        n_cmp++;
        if (mode !== 2'd3) begin n_err++; $display("FAIL solid_mode: got mode %0d want 3", mode); end
        for (int pass = 0; pass < 3; pass++) begin
            if (pass == 1) solid_rgb = 12'hABC;
            if (pass == 2) do_edge();
            for (int i = 0; i <= 4; i++) begin
                if (i < 4) push_px(hv[i], vv[i], 1'b1);
                tick();
                if (i >= 1) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({hs, vs, rgb} !== e) begin
                        n_err++;
                        $display("FAIL solid[%0d.%0d]: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                                 pass, i - 1, hs, vs, rgb, e[13], e[12], e[11:0]);
                    end
                end
            end
        end
        pulse_step();
        do_edge();
        n_cmp++;
        if (mode !== 2'd0) begin n_err++; $display("FAIL mode_wrap: got mode %0d want 0", mode); end
    endtask

    task automatic test_reset_pending();
        pulse_step();
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        m_mode  = 2'd0;
        m_fcnt  = 8'd0;
        m_pend  = 1'b0;
        m_solid = 12'h000;
        n_cmp += 2;
        if (mode !== 2'd0) begin n_err++; $display("FAIL rstpend mode: got %0d want 0", mode); end
        if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL rstpend frame_cnt: got %0d want 0", frame_cnt); end
        do_edge();
        n_cmp += 2;
        if (mode !== 2'd0) begin n_err++; $display("FAIL rstpend no_step: got mode %0d want 0", mode); end
        if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL rstpend frame_cnt_edge: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [13:0] e;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                pulse_step();
                do_edge();
            end
            for (int i = 0; i <= 32; i++) begin
                if (i < 32) push_px(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
                                    1'($urandom_range(0, 1)));
                tick();
                if (i >= 1) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({hs, vs, rgb} !== e) begin
                        n_err++;
                        $display("FAIL b2b[%0d.%0d]: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                                 pass, i - 1, hs, vs, rgb, e[13], e[12], e[11:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bars_blank();
        test_mode_step();
        test_gradient_wrap();
        test_solid();
        test_reset_pending();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter BAR_WIDTH, default 80, width of each colour bar in visible pixels.
REQ-002 SHALL have parameter CHECK_LOG2, default 5, log2 of checkerboard square size in pixels.
REQ-003 SHALL have port clk_vga  input  1  pixel clock, 25 MHz; single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port hs_in  input  1  horizontal sync from the 640x480 timing driver, active-low.
REQ-006 SHALL have port vs_in  input  1  vertical sync from the timing driver, active-low.
REQ-007 SHALL have port hc_visible  input  10  visible column from the driver, 0 when blanked.
REQ-008 SHALL have port vc_visible  input  10  visible row from the driver, 0 when blanked.
REQ-009 SHALL have port mode_step  input  1  one-cycle pulse requesting the next pattern.
REQ-010 SHALL have port solid_rgb  input  12  colour used in solid mode, {R[3:0],G[3:0],B[3:0]}.
REQ-011 SHALL have port hs  output  1  hs_in delayed to align with rgb.
REQ-012 SHALL have port vs  output  1  vs_in delayed to align with rgb.
REQ-013 SHALL have port rgb  output  12  registered pixel colour, {R,G,B} 4 bits each.
REQ-014 SHALL have port mode  output  2  active pattern: 0 bars, 1 checker, 2 gradient, 3 solid.
REQ-015 SHALL have port frame_cnt  output  8  frame counter.

Function
REQ-016 SHALL treat a pixel as visible only when hc_visible != 0 and vc_visible != 0; otherwise rgb SHALL be 12'h000.
REQ-017 SHALL use a 2-stage pipeline: stage 1 registers inputs and visibility, stage 2 registers rgb; rgb, hs and vs SHALL lag their inputs by exactly 2 clk_vga cycles.
REQ-018 SHALL define frame edge as vs_in falling (1 in previous cycle, 0 in current cycle).
REQ-019 SHALL increment frame_cnt by 1 at each frame edge, wrapping 255 -> 0.
REQ-020 SHALL set a pending flag on mode_step = 1; at a frame edge, if the flag or mode_step is set, mode SHALL advance by 1 (wrapping 3 -> 0) and the flag SHALL clear.
REQ-021 SHALL collapse any number of mode_step pulses within one frame into a single mode step.
REQ-022 SHALL sample solid_rgb into an internal register only at frame edges; mid-frame changes SHALL NOT affect output.
REQ-023 Bars: idx = hc_visible / BAR_WIDTH, clamped to 7; colours for idx 0..7 SHALL be FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-024 Checker: rgb SHALL be FFF when hc_visible[CHECK_LOG2] XOR vc_visible[CHECK_LOG2] = 1, else 000.
REQ-025 Gradient: R = hc_visible[9:6] + frame_cnt[3:0] mod 16, G = vc_visible[8:5], B = frame_cnt[7:4].
REQ-026 Solid: rgb SHALL be the sampled solid_rgb.
REQ-027 Pattern computation SHALL use the mode and frame_cnt values registered in stage 1, so a frame edge changes the output from the same pixel for all fields.

Reset
REQ-028 On rst = 1 at a clk_vga edge: rgb = 000, hs = 1, vs = 1, mode = 0, frame_cnt = 0, pending flag = 0, solid register = 000.
REQ-029 Pipeline sync registers SHALL reset to 1 and the stored previous vs_in SHALL reset to 1; this prevents a false frame edge after reset.
REQ-030 Reset asserted mid-frame SHALL discard any pending mode_step.

Structure
REQ-031 Package vga_pkg SHALL hold the mode enum typedef (MODE_BARS, MODE_CHECKER, MODE_GRADIENT, MODE_SOLID), the RGB width constant (12) and the 8-entry bar-colour table.
REQ-032 Colour selection SHALL be a combinational sub-module vga_pattern_lut (mode, hc, vc, frame_cnt, solid -> rgb); all sequential logic stays in vga_pattern_gen.

Verification
REQ-033 Reset, then drive hc_visible = 85, vc_visible = 10, mode 0 -> rgb = FF0 exactly 2 cycles later; hs and vs follow their inputs with the same 2-cycle delay.
REQ-034 Drive hc_visible = 0, vc_visible = 100 (blank) in any mode -> rgb = 000.
REQ-035 Pulse mode_step 3 times mid-frame -> mode unchanged until the next vs_in falling edge, then mode = 1; hc = 32, vc = 0x01 -> rgb = FFF.
REQ-036 Run 256 frame edges -> frame_cnt wraps to 0; in gradient mode at frame_cnt = 0x13, hc = 64, vc = 32 -> rgb = 4'h4, 4'h1, 4'h1 (R, G, B).
REQ-037 Assert mode_step, then assert rst before the frame edge -> after release mode = 0, no step occurs at the next edge, and frame_cnt = 1 after that edge.
REQ-038 Solid mode: change solid_rgb = ABC mid-frame -> output keeps the old colour until the frame edge, then shows ABC.
